// File: rtl/dmem_sram_responder.sv
// Data-memory responder for the CPU M stage: holds stall for LATENCY cycles,
// then performs a word load or byte-lane store on an internal array.
//
// state | meaning
// IDLE  | no access in flight; stall follows req_en combinationally
// WAIT  | request latched; counting down remaining stall cycles
// DONE  | access performed; stall released, rdata valid this cycle
module dmem_sram_responder #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_en,
    input  logic [3:0]  req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        busy
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_sram_responder: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [3:0]        wen_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;

    logic              access;
    logic [3:0]        acc_wen;
    logic [ADDR_W-1:0] acc_idx;
    logic [31:0]       acc_wdata;

    logic [31:0]       mem [2**ADDR_W];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: begin
                stall = req_en;
                if (req_en) begin
                    if (LATENCY == 1) begin
                        access    = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt   = CNT_INIT;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    access    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle latency accesses straight from the live request; otherwise the latched copy.
    always_comb begin
        if (state == IDLE) begin
            acc_wen   = req_wen;
            acc_idx   = req_addr[ADDR_W+1:2];
            acc_wdata = req_wdata;
        end else begin
            acc_wen   = wen_q;
            acc_idx   = idx_q;
            acc_wdata = wdata_q;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            wen_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            rdata   <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req_en) begin
                wen_q   <= req_wen;
                idx_q   <= req_addr[ADDR_W+1:2];
                wdata_q <= req_wdata;
            end
            if (access && acc_wen == 4'b0000) begin
                rdata <= mem[acc_idx];
            end
        end
    end

    // Array is never cleared; reset only aborts the pending access via the state register.
    always_ff @(posedge clk) begin
        if (access) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wen[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Directed bench for dmem_sram_responder: LATENCY=2 instance for timing, lanes,
// back-to-back, reset abort and aliasing; LATENCY=1 instance for the short path.
module tb_dmem_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en0, en1;
    logic [3:0]  wen0, wen1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [31:0] rdata0, rdata1;
    logic        stall0, stall1, busy0, busy1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_sram_responder #(.ADDR_W(12), .LATENCY(2)) dut0 (
        .clk(clk), .rst(rst), .req_en(en0), .req_wen(wen0), .req_addr(addr0),
        .req_wdata(wdata0), .rdata(rdata0), .stall(stall0), .busy(busy0)
    );

    dmem_sram_responder #(.ADDR_W(12), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_en(en1), .req_wen(wen1), .req_addr(addr1),
        .req_wdata(wdata1), .rdata(rdata1), .stall(stall1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge with the DUT idle; returns just after the
    // edge that ends the DONE cycle.
    task automatic access(input int which, input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit chk_rd, input logic [31:0] exp_rd,
                          input bit keep, input string tag);
        int n;
        int lat;
        logic s;
        lat = (which == 1) ? 1 : 2;
        if (which == 1) begin
            en1 = 1'b1; wen1 = wen; addr1 = addr; wdata1 = wdata;
        end else begin
            en0 = 1'b1; wen0 = wen; addr0 = addr; wdata0 = wdata;
        end
        #1;
        check({tag, "_comb_stall"}, 32'((which == 1) ? stall1 : stall0), 32'd1);
        n = 0;
        forever begin
            @(negedge clk);
            s = (which == 1) ? stall1 : stall0;
            if (!s || n > 40) break;
            n++;
        end
        check({tag, "_stall_cycles"}, 32'(n), 32'(lat));
        check({tag, "_busy_done"}, 32'((which == 1) ? busy1 : busy0), 32'd1);
        if (chk_rd) begin
            check({tag, "_rdata"}, (which == 1) ? rdata1 : rdata0, exp_rd);
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            if (which == 1) en1 = 1'b0; else en0 = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0;
        en0 = 1'b0; wen0 = 4'd0; addr0 = 32'd0; wdata0 = 32'd0;
        en1 = 1'b0; wen1 = 4'd0; addr1 = 32'd0; wdata1 = 32'd0;
        #12;
        check("rst_stall0", 32'(stall0), 32'd0);
        check("rst_busy0",  32'(busy0),  32'd0);
        check("rst_rdata0", rdata0,      32'd0);
        check("rst_stall1", 32'(stall1), 32'd0);
        check("rst_busy1",  32'(busy1),  32'd0);
        check("rst_rdata1", rdata1,      32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // basic load after preload
        access(0, 4'hF, 32'h14, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0, "t1_store");
        access(0, 4'h0, 32'h14, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, "t1_load");

        // byte-lane store; stores leave rdata alone
        access(0, 4'hF, 32'h0C, 32'h1122_3344, 1'b1, 32'hDEAD_BEEF, 1'b0, "t2_store_full");
        access(0, 4'b0101, 32'h0C, 32'hAABB_CCDD, 1'b1, 32'hDEAD_BEEF, 1'b0, "t2_store_lane");
        access(0, 4'h0, 32'h0C, 32'd0, 1'b1, 32'h11BB_33DD, 1'b0, "t2_load");

        // back-to-back loads with req_en held high
        access(0, 4'hF, 32'h0, 32'h1111_0000, 1'b0, 32'd0, 1'b0, "t3_store0");
        access(0, 4'hF, 32'h4, 32'h0000_2222, 1'b0, 32'd0, 1'b0, "t3_store4");
        access(0, 4'h0, 32'h0, 32'd0, 1'b1, 32'h1111_0000, 1'b1, "t3_load0");
        access(0, 4'h0, 32'h4, 32'd0, 1'b1, 32'h0000_2222, 1'b0, "t3_load4");
        @(negedge clk);
        check("t3_idle_stall", 32'(stall0), 32'd0);
        check("t3_idle_busy",  32'(busy0),  32'd0);
        @(posedge clk);
        #1;

        // reset during WAIT of a store drops the write
        access(0, 4'hF, 32'h8, 32'h0, 1'b0, 32'd0, 1'b0, "t4_store_old");
        en0 = 1'b1; wen0 = 4'hF; addr0 = 32'h8; wdata0 = 32'hFFFF_FFFF;
        @(posedge clk);
        #2;
        check("t4_in_wait_busy", 32'(busy0), 32'd1);
        rst = 1'b0;
        en0 = 1'b0;
        #1;
        check("t4_rst_stall", 32'(stall0), 32'd0);
        check("t4_rst_rdata", rdata0,      32'd0);
        check("t4_rst_busy",  32'(busy0),  32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        access(0, 4'h0, 32'h8, 32'd0, 1'b1, 32'h0, 1'b0, "t4_load");

        // aliasing above the index bits
        access(0, 4'hF, 32'h0000_4000, 32'h0000_5A5A, 1'b0, 32'd0, 1'b0, "t5_store");
        access(0, 4'h0, 32'h0000_0000, 32'd0, 1'b1, 32'h0000_5A5A, 1'b0, "t5_alias");

        // single-cycle latency instance
        access(1, 4'hF, 32'h10, 32'hCAFE_F00D, 1'b1, 32'd0, 1'b0, "t6_store");
        access(1, 4'h0, 32'h10, 32'd0, 1'b1, 32'hCAFE_F00D, 1'b0, "t6_load");
        @(negedge clk);
        check("t6_idle_stall", 32'(stall1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
